hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 174 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Pipeline interlock for an in-order core with one multi-cycle FP unit.
// It detects load-use hazards against the EXE-stage load, and RAW/WAW/
// structural hazards against the single long op in flight. It also tracks
// that op until it writes back.
//
// Parameters
//   LAT           latency of the long FP unit, issue edge to write-back (2..15)
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   id_*          ID-stage instruction: sources (addr, file, used), dest
//                 (addr, file, write enable), valid, long-op flag
//   exe_mem_read  EXE holds a load; exe_rd / exe_rd_fp give its destination
//   flush         branch redirect, kills the ID instruction this cycle
//   stall         combinational: freeze PC/IF/ID and bubble EXE
//   lu_busy       registered: long unit occupied (BUSY or DONE)
//   lu_wb_*       registered: long-unit write-back strobe, dest, file select
//   stall_cnt     saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_fp,
   input  logic        id_rs2_fp,
   input  logic        id_rs1_use,
   input  logic        id_rs2_use,
   input  logic [4:0]  id_rd,
   input  logic        id_rd_fp,
   input  logic        id_rd_we,
   input  logic        id_is_long,
   input  logic        exe_mem_read,
   input  logic [4:0]  exe_rd,
   input  logic        exe_rd_fp,
   input  logic        flush,
   output logic        stall,
   output logic        lu_busy,
   output logic        lu_wb_valid,
   output logic [4:0]  lu_wb_rd,
   output logic        lu_wb_fp,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // BUSY lasts LAT-1 cycles (cnt LAT-2 down to 0), then DONE for one cycle.
   localparam logic [3:0] CNT_INIT = 4'(LAT - 2);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [4:0]  pend_rd_reg;
   logic        pend_fp_reg;
   logic        lu_busy_reg;
   logic        lu_wb_valid_reg;
   logic [4:0]  lu_wb_rd_reg;
   logic        lu_wb_fp_reg;
   logic [15:0] stall_cnt_reg;

   logic        not_idle;
   logic        waw_hit;
   logic        hazard;
   logic        issue;

   // Integer x0 is hard-wired zero and never creates a dependency; f0 does.
   function automatic logic reg_match(input logic [4:0] a, input logic a_fp,
                                      input logic [4:0] b, input logic b_fp);
      return (a == b) && (a_fp == b_fp) && !((a == 5'd0) && !a_fp);
   endfunction

   logic [4:0] src_addr [2];
   logic       src_fp   [2];
   logic       src_use  [2];
   logic [1:0] load_hit;
   logic [1:0] raw_hit;

   assign src_addr[0] = id_rs1;
   assign src_addr[1] = id_rs2;
   assign src_fp[0]   = id_rs1_fp;
   assign src_fp[1]   = id_rs2_fp;
   assign src_use[0]  = id_rs1_use;
   assign src_use[1]  = id_rs2_use;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src
         assign load_hit[gi] = src_use[gi] &&
                               reg_match(src_addr[gi], src_fp[gi], exe_rd, exe_rd_fp);
         assign raw_hit[gi]  = src_use[gi] &&
                               reg_match(src_addr[gi], src_fp[gi], pend_rd_reg, pend_fp_reg);
      end
   endgenerate

   assign not_idle = (state_reg != IDLE);
   assign waw_hit  = id_rd_we && reg_match(id_rd, id_rd_fp, pend_rd_reg, pend_fp_reg);

   // All hazard kinds OR into one stall, so coincident hazards count once.
   // While not IDLE a new long op is always blocked (including in DONE).
   assign hazard = (exe_mem_read && (|load_hit)) ||
                   (not_idle && ((|raw_hit) || waw_hit || id_is_long));
   assign stall  = id_valid && !flush && hazard;
   assign issue  = id_valid && id_is_long && !stall && !flush;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      unique case (state_reg)
         IDLE: begin
            if (issue) begin
               state_next = BUSY;
               cnt_next   = CNT_INIT;
            end
         end
         BUSY: begin
            if (cnt_reg == 4'd0) begin
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            cnt_next   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= 4'd0;
         pend_rd_reg     <= 5'd0;
         pend_fp_reg     <= 1'b0;
         lu_busy_reg     <= 1'b0;
         lu_wb_valid_reg <= 1'b0;
         lu_wb_rd_reg    <= 5'd0;
         lu_wb_fp_reg    <= 1'b0;
         stall_cnt_reg   <= 16'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (issue) begin
            pend_rd_reg <= id_rd;
            pend_fp_reg <= id_rd_fp;
         end
         // Outputs are registered from the next state so they line up
         // exactly with the state they describe.
         lu_busy_reg     <= (state_next != IDLE);
         lu_wb_valid_reg <= (state_next == DONE);
         if (state_next == DONE) begin
            lu_wb_rd_reg <= pend_rd_reg;
            lu_wb_fp_reg <= pend_fp_reg;
         end
         if (stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
         end
      end
   end

   assign lu_busy     = lu_busy_reg;
   assign lu_wb_valid = lu_wb_valid_reg;
   assign lu_wb_rd    = lu_wb_rd_reg;
   assign lu_wb_fp    = lu_wb_fp_reg;
   assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed scenarios for hazard_scoreboard. A small model tracks the long op
// by its age in cycles since issue and derives the expected stall, busy,
// write-back and stall count. A negedge process compares the DUT with that
// model every cycle. Literal expectations in the scenarios pin the model.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

   localparam int LAT = 4;

   logic        clk;
   logic        rst_n = 1'b0;
   logic        id_valid, id_rs1_fp, id_rs2_fp, id_rs1_use, id_rs2_use;
   logic [4:0]  id_rs1, id_rs2, id_rd, exe_rd;
   logic        id_rd_fp, id_rd_we, id_is_long, exe_mem_read, exe_rd_fp, flush;
   logic        stall, lu_busy, lu_wb_valid, lu_wb_fp;
   logic [4:0]  lu_wb_rd;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: age of the in-flight long op (-1 = none), its destination,
   // and the expected saturating stall count.
   int         m_age = -1;
   logic [4:0] m_prd = 5'd0;
   logic       m_pfp = 1'b0;
   int         m_cnt = 0;

   hazard_scoreboard #(.LAT(LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_fp    (id_rs1_fp),
      .id_rs2_fp    (id_rs2_fp),
      .id_rs1_use   (id_rs1_use),
      .id_rs2_use   (id_rs2_use),
      .id_rd        (id_rd),
      .id_rd_fp     (id_rd_fp),
      .id_rd_we     (id_rd_we),
      .id_is_long   (id_is_long),
      .exe_mem_read (exe_mem_read),
      .exe_rd       (exe_rd),
      .exe_rd_fp    (exe_rd_fp),
      .flush        (flush),
      .stall        (stall),
      .lu_busy      (lu_busy),
      .lu_wb_valid  (lu_wb_valid),
      .lu_wb_rd     (lu_wb_rd),
      .lu_wb_fp     (lu_wb_fp),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_same(input logic [4:0] a, input logic af,
                                 input logic [4:0] b, input logic bf);
      if (a != b || af != bf) return 1'b0;
      if (a == 5'd0 && !af) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_stall();
      bit h;
      h = 1'b0;
      if (exe_mem_read) begin
         if (id_rs1_use && m_same(id_rs1, id_rs1_fp, exe_rd, exe_rd_fp)) h = 1'b1;
         if (id_rs2_use && m_same(id_rs2, id_rs2_fp, exe_rd, exe_rd_fp)) h = 1'b1;
      end
      if (m_age >= 0) begin
         if (id_rs1_use && m_same(id_rs1, id_rs1_fp, m_prd, m_pfp)) h = 1'b1;
         if (id_rs2_use && m_same(id_rs2, id_rs2_fp, m_prd, m_pfp)) h = 1'b1;
         if (id_rd_we && m_same(id_rd, id_rd_fp, m_prd, m_pfp)) h = 1'b1;
         if (id_is_long) h = 1'b1;
      end
      return id_valid && !flush && h;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_age <= -1;
         m_prd <= 5'd0;
         m_pfp <= 1'b0;
         m_cnt <= 0;
      end else begin
         if (m_stall() && m_cnt < 65535) m_cnt <= m_cnt + 1;
         if (id_valid && id_is_long && !flush && !m_stall()) begin
            m_age <= 0;
            m_prd <= id_rd;
            m_pfp <= id_rd_fp;
         end else if (m_age >= 0) begin
            m_age <= (m_age == LAT - 1) ? -1 : m_age + 1;
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_stall", 32'(stall), 32'(m_stall()));
      check("cmp_busy", 32'(lu_busy), 32'(m_age >= 0));
      check("cmp_wb_valid", 32'(lu_wb_valid), 32'(m_age == LAT - 1));
      if (m_age == LAT - 1) begin
         check("cmp_wb_rd", 32'(lu_wb_rd), 32'(m_prd));
         check("cmp_wb_fp", 32'(lu_wb_fp), 32'(m_pfp));
      end
      check("cmp_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_fp = 0; id_rs2_fp = 0;
      id_rs1_use = 0; id_rs2_use = 0; id_rd = 0; id_rd_fp = 0; id_rd_we = 0;
      id_is_long = 0; exe_mem_read = 0; exe_rd = 0; exe_rd_fp = 0; flush = 0;
   endtask

   task automatic drive_long(input logic [4:0] rd);
      id_valid = 1; id_is_long = 1; id_rd = rd; id_rd_fp = 1; id_rd_we = 1;
   endtask

   initial begin
      int stalled;
      clr();
      tick();
      tick();
      check("rst_busy", 32'(lu_busy), 32'd0);
      check("rst_wb_valid", 32'(lu_wb_valid), 32'd0);
      check("rst_wb_rd", 32'(lu_wb_rd), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      rst_n = 1'b1;
      tick();

      // Load-use on x5, then x0 (never a hazard), then f0 (is a hazard).
      exe_mem_read = 1; exe_rd = 5; id_valid = 1; id_rs1 = 5; id_rs1_use = 1;
      #1 check("s1_stall_x5", 32'(stall), 32'd1);
      tick();
      check("s1_cnt1", 32'(stall_cnt), 32'd1);
      exe_rd = 0; id_rs1 = 0;
      #1 check("s1_stall_x0", 32'(stall), 32'd0);
      exe_rd_fp = 1; id_rs1_fp = 1;
      #1 check("s1_stall_f0", 32'(stall), 32'd1);
      tick();
      check("s1_cnt2", 32'(stall_cnt), 32'd2);
      clr();
      tick();

      // Long op into f3: busy from the issue edge, write-back after edge 3.
      drive_long(5'd3);
      tick();
      clr();
      check("s2_busy_e0", 32'(lu_busy), 32'd1);
      check("s2_wb_e0", 32'(lu_wb_valid), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("s2_wb", 32'(lu_wb_valid), 32'(k == 3));
         check("s2_busy", 32'(lu_busy), 32'(k <= 3));
         if (k == 3) begin
            check("s2_wb_rd", 32'(lu_wb_rd), 32'd3);
            check("s2_wb_fp", 32'(lu_wb_fp), 32'd1);
         end
      end

      // RAW on f3 stalls for the four non-IDLE cycles.
      drive_long(5'd3);
      tick();
      clr();
      id_valid = 1; id_rs1 = 3; id_rs1_fp = 1; id_rs1_use = 1;
      stalled = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (!stall) break;
         stalled++;
         tick();
      end
      check("s3_raw_cycles", 32'(stalled), 32'd4);
      clr();
      tick();
      drive_long(5'd3);
      tick();
      clr();
      id_valid = 1; id_rs1 = 3; id_rs1_fp = 0; id_rs1_use = 1;
      #1 check("s3_int_x3", 32'(stall), 32'd0);
      id_rs1_use = 0; id_rd = 3; id_rd_fp = 1; id_rd_we = 1;
      #1 check("s3_waw_f3", 32'(stall), 32'd1);
      clr();
      repeat (5) tick();

      // Structural hazard, then flushed: no issue, original op still completes.
      drive_long(5'd3);
      tick();
      clr();
      drive_long(5'd7);
      #1 check("s4_struct", 32'(stall), 32'd1);
      flush = 1;
      #1 check("s4_flush", 32'(stall), 32'd0);
      tick();
      clr();
      tick();
      tick();
      check("s4_wb_valid", 32'(lu_wb_valid), 32'd1);
      check("s4_wb_rd", 32'(lu_wb_rd), 32'd3);
      tick();
      check("s4_idle", 32'(lu_busy), 32'd0);
      tick();
      check("s4_no_ghost", 32'(lu_busy), 32'd0);

      // Reset while BUSY discards the op.
      drive_long(5'd5);
      tick();
      clr();
      tick();
      rst_n = 1'b0;
      #1;
      check("s5_busy", 32'(lu_busy), 32'd0);
      check("s5_wb", 32'(lu_wb_valid), 32'd0);
      check("s5_cnt", 32'(stall_cnt), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("s5_no_wb", 32'(lu_wb_valid), 32'd0);
      end

      // Saturation of the stall counter.
      exe_mem_read = 1; exe_rd = 9; id_valid = 1; id_rs2 = 9; id_rs2_use = 1;
      repeat (65540) tick();
      check("s6_sat", 32'(stall_cnt), 32'h0000FFFF);
      tick();
      check("s6_hold", 32'(stall_cnt), 32'h0000FFFF);
      clr();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
